// File: rtl/signed_bcd_decoder.sv
// Signed/unsigned result word to sign + BCD digits, using an iterative double-dabble engine.
// Optional build macro SIGNED_BCD_BLANK_EN replaces leading zero digits with 4'hF.
module signed_bcd_decoder #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic                  in_signed,
   input  logic                  in_ovf,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_sign,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  out_ovf,
   output logic                  busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic            sign_q, sign_d;
   logic            ovf_q, ovf_d;
   logic            out_sign_q, out_sign_d;
   logic [BW-1:0]   out_bcd_q, out_bcd_d;
   logic            out_ovf_q, out_ovf_d;

   logic [WIDTH-1:0] mag;
   logic [BW-1:0]    bcd_adj;
   logic [BW-1:0]    bcd_shift;
   logic [BW-1:0]    bcd_disp;

   // The two's complement of the most-negative word is the same bit pattern, which
   // read as unsigned is exactly its magnitude, so WIDTH bits suffice.
   always_comb begin
      mag = in_data;
      if (in_signed && in_data[WIDTH-1]) begin
         mag = ~in_data + WIDTH'(1);
      end
   end

   // One double-dabble step: correct each digit, then shift the next magnitude bit in.
   always_comb begin
      bcd_adj = bcd_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) begin
            bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
         end
      end
      bcd_shift = {bcd_adj[BW-2:0], shift_q[WIDTH-1]};
   end

`ifdef SIGNED_BCD_BLANK_EN
   logic lead;

   always_comb begin
      bcd_disp = bcd_shift;
      lead     = 1'b1;
      for (int d = DIGITS - 1; d >= 1; d--) begin
         if (lead && (bcd_shift[4*d +: 4] == 4'd0)) begin
            bcd_disp[4*d +: 4] = 4'hF;
         end else begin
            lead = 1'b0;
         end
      end
   end
`else
   always_comb begin
      bcd_disp = bcd_shift;
   end
`endif

   // NOTE: every signal written here gets a default first, so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      bcd_d      = bcd_q;
      sign_d     = sign_q;
      ovf_d      = ovf_q;
      out_sign_d = out_sign_q;
      out_bcd_d  = out_bcd_q;
      out_ovf_d  = out_ovf_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d  = in_signed & in_data[WIDTH-1];
               ovf_d   = in_ovf;
               bcd_d   = '0;
               shift_d = mag;
               cnt_d   = CW'(WIDTH);
               state_d = CONV;
            end
         end
         CONV: begin
            bcd_d   = bcd_shift;
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d    = DONE;
               out_sign_d = sign_q;
               out_bcd_d  = bcd_disp;
               out_ovf_d  = ovf_q;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         bcd_q      <= '0;
         sign_q     <= 1'b0;
         ovf_q      <= 1'b0;
         out_sign_q <= 1'b0;
         out_bcd_q  <= '0;
         out_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         bcd_q      <= bcd_d;
         sign_q     <= sign_d;
         ovf_q      <= ovf_d;
         out_sign_q <= out_sign_d;
         out_bcd_q  <= out_bcd_d;
         out_ovf_q  <= out_ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == CONV);
   assign out_valid = (state_q == DONE);
   assign out_sign  = out_sign_q;
   assign out_bcd   = out_bcd_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_signed_bcd_decoder.sv
// Directed bench for signed_bcd_decoder: vector table plus backpressure and mid-conversion reset sequences.
// Define SIGNED_BCD_BLANK_EN for both RTL and bench to check the blanking build.
module tb_signed_bcd_decoder;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data;
   logic              in_signed;
   logic              in_ovf;
   logic              out_valid;
   logic              out_ready;
   logic              out_sign;
   logic [4*DIGITS-1:0] out_bcd;
   logic              out_ovf;
   logic              busy;

   int n_cmp = 0;
   int n_err = 0;

   signed_bcd_decoder #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_signed (in_signed),
      .in_ovf    (in_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_bcd   (out_bcd),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0]  data;
      logic        sgn;
      logic        ovf;
      logic        exp_sign;
      logic [11:0] exp_bcd;
      logic [11:0] exp_blank;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [11:0] pick(input logic [11:0] plain, input logic [11:0] blank);
`ifdef SIGNED_BCD_BLANK_EN
      return blank;
`else
      return plain;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic apply_word(input logic [7:0] d, input logic s, input logic o);
      bit got;
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      in_signed = s;
      in_ovf    = o;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (in_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("in_ready_before_accept", 32'(got), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = ~d;
      in_ovf   = ~o;
      check("busy_after_accept", 32'(busy), 32'd1);
      check("in_ready_in_conv", 32'(in_ready), 32'd0);
   endtask

   task automatic wait_valid(input string name);
      int lat;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      check({name, "_latency"}, 32'(lat), 32'd8);
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("out_valid_after_release", 32'(out_valid), 32'd0);
      check("in_ready_after_release", 32'(in_ready), 32'd1);
   endtask

   initial begin
      //           data    sgn   ovf   sign  bcd      blanked  ovf
      vecs[0] = '{8'h28, 1'b1, 1'b0, 1'b0, 12'h040, 12'hF40, 1'b0};
      vecs[1] = '{8'hEC, 1'b1, 1'b0, 1'b1, 12'h020, 12'hF20, 1'b0};
      vecs[2] = '{8'hEC, 1'b0, 1'b0, 1'b0, 12'h236, 12'h236, 1'b0};
      vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b1, 12'h128, 12'h128, 1'b1};
      vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 12'h255, 12'h255, 1'b0};
      vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 12'h001, 12'hFF1, 1'b1};
      vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b0, 12'h000, 12'hFF0, 1'b0};
      vecs[7] = '{8'h7F, 1'b1, 1'b0, 1'b0, 12'h127, 12'h127, 1'b0};
      vecs[8] = '{8'h05, 1'b1, 1'b0, 1'b0, 12'h005, 12'hFF5, 1'b0};
      vecs[9] = '{8'h80, 1'b0, 1'b0, 1'b0, 12'h128, 12'h128, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h55;
      in_signed = 1'b1;
      in_ovf    = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_sign", 32'(out_sign), 32'd0);
      check("rst_out_bcd", 32'(out_bcd), 32'd0);
      check("rst_out_ovf", 32'(out_ovf), 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;

      for (int v = 0; v < 10; v++) begin
         apply_word(vecs[v].data, vecs[v].sgn, vecs[v].ovf);
         wait_valid($sformatf("vec%0d", v));
         check($sformatf("vec%0d_sign", v), 32'(out_sign), 32'(vecs[v].exp_sign));
         check($sformatf("vec%0d_bcd", v), 32'(out_bcd),
               32'(pick(vecs[v].exp_bcd, vecs[v].exp_blank)));
         check($sformatf("vec%0d_ovf", v), 32'(out_ovf), 32'(vecs[v].exp_ovf));
         release_result();
      end

      // Backpressure: results must hold while in_valid and in_data churn.
      apply_word(8'hEC, 1'b1, 1'b0);
      wait_valid("bp");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         in_data   = k[0] ? 8'h11 : 8'h99;
         in_signed = 1'b0;
         in_ovf    = 1'b1;
         out_ready = 1'b0;
         @(posedge clk);
         #1;
         check($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
         check($sformatf("bp%0d_bcd", k), 32'(out_bcd), 32'(pick(12'h020, 12'hF20)));
         check($sformatf("bp%0d_sign", k), 32'(out_sign), 32'd1);
         check($sformatf("bp%0d_ovf", k), 32'(out_ovf), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h28;
      in_signed = 1'b1;
      in_ovf    = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_release_out_valid", 32'(out_valid), 32'd0);
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_next_accept_busy", 32'(busy), 32'd1);
      wait_valid("bp_next");
      check("bp_next_bcd", 32'(out_bcd), 32'(pick(12'h040, 12'hF40)));
      check("bp_next_sign", 32'(out_sign), 32'd0);
      release_result();

      // Reset in the middle of a conversion discards the word.
      apply_word(8'hEC, 1'b1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_sign", 32'(out_sign), 32'd0);
      check("midrst_bcd", 32'(out_bcd), 32'd0);
      check("midrst_ovf", 32'(out_ovf), 32'd0);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
         end
         check("midrst_no_out_valid", 32'(seen), 32'd0);
      end
      apply_word(8'h05, 1'b1, 1'b0);
      wait_valid("postrst");
      check("postrst_bcd", 32'(out_bcd), 32'(pick(12'h005, 12'hFF5)));
      check("postrst_sign", 32'(out_sign), 32'd0);
      check("postrst_ovf", 32'(out_ovf), 32'd0);
      release_result();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/signed_bcd_decoder.md
Name: signed_bcd_decoder

Overview:
- Sequential result decoder for the 8-bit add/sub datapath. Takes one 8-bit result word plus its overflow flag and produces a sign bit and decimal BCD digits for display or logging.
- Treats the word as two's complement or unsigned, as selected per word, and converts the magnitude to BCD with an iterative shift-add-3 (double-dabble) engine.
- Sits downstream of the arithmetic unit and replaces software-side sign/magnitude formatting of results.

Parameters:
- WIDTH, 8, input word width in bits.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH; the default 3 covers 0..255.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  decoder can accept a word.
- in_data  input  WIDTH  result word to decode.
- in_signed  input  1  1 = two's complement, 0 = unsigned.
- in_ovf  input  1  overflow flag accompanying the word.
- out_valid  output  1  decoded result available.
- out_ready  input  1  consumer accepts the result.
- out_sign  output  1  1 = negative.
- out_bcd  output  4*DIGITS  BCD digits; the most significant digit is in the top nibble.
- out_ovf  output  1  registered copy of in_ovf for this word.
- busy  output  1  conversion in progress.

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, busy=0, out_sign=0, out_bcd=0, out_ovf=0, iteration counter=0. Reset wins over all other inputs, including mid-conversion and while in DONE; the in-flight word is discarded with no out_valid.
- FSM states: IDLE, CONV, DONE. in_ready=1 only in IDLE. busy=1 only in CONV. out_valid=1 only in DONE.
- IDLE: an edge with in_valid=1 accepts the word.
  - Compute mag: if in_signed and in_data[WIDTH-1], mag = (~in_data + 1), zero-extended to WIDTH+1 bits; otherwise mag = in_data.
  - Most-negative input (0x80 when signed) gives mag = 128; it must not wrap to 0.
  - Latch sign = in_signed & in_data[WIDTH-1], and latch in_ovf.
  - Clear the BCD register, load the shift register with mag, set counter=WIDTH, go to CONV.
- CONV: each cycle, first add 3 to every BCD digit >= 5, then shift {bcd, shift_reg} left by one bit and decrement the counter.
  - Use only the low WIDTH bits of mag for shifting (mag = 128 fits, since 2^WIDTH-1 >= 128 is not needed: bit pattern 0x80 is shifted directly).
  - When the counter reaches 0, go to DONE.
  - Latency: out_valid rises exactly WIDTH cycles after the accept edge (8 cycles at default).
- DONE: out_sign, out_bcd and out_ovf are stable and held while out_valid=1 and out_ready=0.
  - An edge with out_ready=1 returns to IDLE; in_ready is 1 from the next cycle.
  - No same-cycle accept in DONE; throughput is one word per WIDTH+2 cycles minimum.
- Outputs keep their last values in IDLE and CONV. They update only on the transition into DONE.
- in_valid while not in IDLE is ignored; in_data and in_ovf changes are ignored after the accept edge.
- Zero result: out_sign=0 even for signed input 0x00; a negative zero is never produced.
- out_ovf is informational only. Digits always show the wrapped 8-bit result.

Optional Feature:
- Macro: SIGNED_BCD_BLANK_EN.
- Defined: leading-zero blanking. In out_bcd, each zero digit above the most significant non-zero digit is driven as 4'hF. The units digit is never blanked; value 0 gives {F,F,0}.
- Undefined: all digits are plain BCD with leading zeros, e.g. {0,4,0}.
- FSM, handshake and latency are identical in both builds.

Test Plan (default parameters, macro undefined unless stated):
- in_data=0x28, in_signed=1, in_ovf=0, out_ready=1 -> out_valid 8 cycles after accept; sign=0, out_bcd=0x040, out_ovf=0.
- in_data=0xEC (-20), in_signed=1 -> sign=1, out_bcd=0x020. Same word with in_signed=0 -> sign=0, out_bcd=0x236.
- in_data=0x80, in_signed=1, in_ovf=1 -> sign=1, out_bcd=0x128, out_ovf=1. in_data=0xFF, in_signed=0 -> sign=0, out_bcd=0x255.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid held 1 and in_data toggling -> outputs unchanged and in_ready=0 throughout; one out_ready=1 edge -> IDLE; the next word is accepted the following cycle.
- rst=1 pulsed at cycle 4 of CONV -> next cycle all outputs at reset values and no out_valid; a following word 0x05 (signed) -> out_bcd=0x005, sign=0.
- SIGNED_BCD_BLANK_EN defined: 0x05 -> out_bcd=0xFF5; 0x00 -> 0xFF0; 0xEC signed -> 0xF20 with sign=1.
